// File: rtl/arm_pkg.sv
// Definitions shared by the ARM pipeline's data-memory path: SRAM controller
// state encoding, data-memory base address and SRAM data width.
package arm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } sram_state_t;

  localparam int DATA_MEM_BASE = 1024;
  localparam int SRAM_DW       = 16;

endpackage

// File: rtl/sram_ctrl_if.sv
// MEM-stage data-memory bus between the pipeline (master) and the SRAM
// controller (slave), plus the controller's FSM state for observation.
interface sram_ctrl_if;
  import arm_pkg::*;

  // Handshake: the master raises rd_en and/or wr_en together with address and
  // write_data and holds them until it sees ready=1; that ready cycle completes
  // the access (read_data valid for reads). ready=1 with no request means idle.
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  sram_state_t state;

  modport master (
    output rd_en, wr_en, address, write_data,
    input  read_data, ready, state
  );

  modport slave (
    input  rd_en, wr_en, address, write_data,
    output read_data, ready, state
  );

endinterface

// File: rtl/sram_phase_counter.sv
// Cycle counter timing one half-word phase; last flags the phase's final cycle.
module sram_phase_counter #(
  parameter int HALF_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic last
);

  logic [3:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= 4'd0;
    end else if (inc) begin
      count_q <= count_q + 4'd1;
    end
  end

  assign last = (count_q == 4'(HALF_CYCLES - 1));

endmodule

// File: rtl/sram_ctrl.sv
// Data-memory controller: splits each 32-bit access into two half-word phases
// on an external 16-bit asynchronous SRAM; ready drops while an access runs.
module sram_ctrl
  import arm_pkg::*;
#(
  parameter int BASE_ADDR   = DATA_MEM_BASE,
  parameter int HALF_CYCLES = 2,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  sram_ctrl_if.slave         bus,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  sram_state_t        state_q, state_d;
  logic [SRAM_AW-2:0] widx_q;
  logic [31:0]        wdata_q;
  logic               is_wr_q;
  logic [31:0]        rdata_q;
  logic               req;
  logic               in_phase;
  logic               last;

  assign req      = bus.rd_en | bus.wr_en;
  assign in_phase = (state_q == LOW) || (state_q == HIGH);

  sram_phase_counter #(
    .HALF_CYCLES (HALF_CYCLES)
  ) u_phase_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (!in_phase || last),
    .inc   (in_phase),
    .last  (last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = LOW;
      LOW:     if (last) state_d = HIGH;
      HIGH:    if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      widx_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      // A request with both enables set is a write.
      if (state_q == IDLE && req) begin
        widx_q  <= (SRAM_AW-1)'((bus.address - 32'(BASE_ADDR)) >> 2);
        wdata_q <= bus.write_data;
        is_wr_q <= bus.wr_en;
      end
      if (!is_wr_q && last && state_q == LOW)  rdata_q[15:0]  <= sram_dq_in;
      if (!is_wr_q && last && state_q == HIGH) rdata_q[31:16] <= sram_dq_in;
    end
  end

  // Strobe released in each phase's final cycle so the address is stable around it.
  assign sram_addr     = {widx_q, state_q == HIGH};
  assign sram_dq_out   = (state_q == HIGH) ? wdata_q[31:16] : wdata_q[15:0];
  assign sram_dq_oe    = is_wr_q && in_phase;
  assign sram_we_n     = !(is_wr_q && in_phase && !last);

  assign bus.ready     = (state_q == IDLE && !req) || (state_q == DONE);
  assign bus.read_data = rdata_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: reset checks, directed vector table, mid-access reset
// and randomized accesses against a word-level memory model.
module tb_sram_ctrl;
  import arm_pkg::*;

  localparam int H   = 2;
  localparam int AW  = 18;
  localparam int NRAND = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out;
  logic [15:0]   sram_dq_in;
  logic          sram_dq_oe;
  logic          sram_we_n;

  sram_ctrl_if bus();

  sram_ctrl #(
    .BASE_ADDR   (1024),
    .HALF_CYCLES (H),
    .SRAM_AW     (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_in  (sram_dq_in),
    .sram_dq_oe  (sram_dq_oe),
    .sram_we_n   (sram_we_n)
  );

  always #5 clk = ~clk;

  // External SRAM: written on any clock edge where the strobe is low.
  logic [15:0] sram_mem [0:(1<<AW)-1];
  int we_strobes = 0;
  initial for (int i = 0; i < (1<<AW); i++) sram_mem[i] = 16'h0;
  always @(posedge clk) begin
    if (sram_we_n === 1'b0) begin
      sram_mem[sram_addr] <= sram_dq_out;
      we_strobes <= we_strobes + 1;
    end
  end
  assign sram_dq_in = sram_mem[sram_addr];

  // Reference model: word-addressed memory and last completed read.
  logic [31:0] ref_mem [int];
  logic [31:0] ref_rd = 32'h0;
  int writes_done = 0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic run_access(input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input bit keep, input bit perturb,
                            output logic [31:0] got);
    int w;
    bit is_wr;
    int rdy_low, addr_bad, dq_bad, oe_bad, we_bad, we_low;
    logic [31:0] exp_addr;
    logic [15:0] exp_dq;
    bit exp_we_n;
    is_wr = wr;
    w = int'(((addr - 32'd1024) >> 2) % 32'h20000);
    if (is_wr) begin
      ref_mem[w] = wdata;
      writes_done++;
    end else begin
      ref_rd = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    end
    rdy_low = 0; addr_bad = 0; dq_bad = 0; oe_bad = 0; we_bad = 0; we_low = 0;

    @(negedge clk);
    bus.rd_en = rd; bus.wr_en = wr; bus.address = addr; bus.write_data = wdata;
    #1;
    chk("accept_state_idle", 32'(bus.state), 32'(IDLE));
    chk("accept_ready_low", 32'(bus.ready), 32'd0);

    for (int k = 1; k <= 2*H; k++) begin
      @(negedge clk);
      if (!bus.ready) rdy_low++;
      exp_addr = 32'(w) * 2 + ((k > H) ? 32'd1 : 32'd0);
      if (32'(sram_addr) !== exp_addr) addr_bad++;
      exp_dq = (k > H) ? wdata[31:16] : wdata[15:0];
      if (is_wr && sram_dq_out !== exp_dq) dq_bad++;
      if (sram_dq_oe !== is_wr) oe_bad++;
      exp_we_n = !(is_wr && ((k - 1) % H) != H - 1);
      if (sram_we_n !== exp_we_n) we_bad++;
      if (sram_we_n === 1'b0) we_low++;
      if (perturb) begin
        bus.address    = 32'd1024 + 4 * $urandom_range(0, 31);
        bus.write_data = $urandom;
        bus.rd_en      = 1'($urandom_range(0, 1));
        bus.wr_en      = 1'($urandom_range(0, 1));
      end
    end
    chk("ready_low_cycles", rdy_low, 2*H);
    chk("phase_addr_errs", addr_bad, 0);
    chk("phase_dq_errs", dq_bad, 0);
    chk("phase_oe_errs", oe_bad, 0);
    chk("phase_we_n_errs", we_bad, 0);
    chk("we_low_cycles", we_low, is_wr ? 2*(H-1) : 0);

    @(negedge clk);
    chk("done_state", 32'(bus.state), 32'(DONE));
    chk("done_ready", 32'(bus.ready), 32'd1);
    chk("done_read_data", bus.read_data, ref_rd);
    got = bus.read_data;
    if (!keep) begin
      bus.rd_en = 1'b0; bus.wr_en = 1'b0;
    end
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          keep;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] got;
    bit op_rd, op_wr;

    vecs[0] = '{1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 1'b0, 32'h00000000};
    vecs[1] = '{1'b1, 1'b0, 32'd1032, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b1, 32'd1028, 32'hCAFEF00D, 1'b0, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b1, 32'd1024, 32'h12345678, 1'b1, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 1'b0, 32'd1028, 32'h0,        1'b0, 32'hCAFEF00D};
    vecs[5] = '{1'b1, 1'b1, 32'd1036, 32'hA5A55A5A, 1'b0, 32'hCAFEF00D};
    vecs[6] = '{1'b1, 1'b0, 32'd1036, 32'h0,        1'b0, 32'hA5A55A5A};
    vecs[7] = '{1'b1, 1'b0, 32'd1024, 32'h0,        1'b0, 32'h12345678};
    vecs[8] = '{1'b0, 1'b1, 32'h00080408, 32'h0BAD0BAD, 1'b0, 32'h12345678};
    vecs[9] = '{1'b1, 1'b0, 32'd1032, 32'h0,        1'b0, 32'h0BAD0BAD};

    // Reset held for 3 cycles with a read request pending.
    bus.rd_en = 1'b1; bus.wr_en = 1'b0; bus.address = 32'd1032; bus.write_data = 32'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_state", 32'(bus.state), 32'(IDLE));
      chk("rst_we_n", 32'(sram_we_n), 32'd1);
      chk("rst_oe", 32'(sram_dq_oe), 32'd0);
      chk("rst_read_data", bus.read_data, 32'h0);
    end
    rst = 1'b0; bus.rd_en = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    chk("rst_dq_out", 32'(sram_dq_out), 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].keep, 1'b0, got);
      chk($sformatf("vec%0d_read_data", i), got, vecs[i].exp_rd);
    end

    // Reset in the second cycle of a read's HIGH phase.
    run_access(1'b0, 1'b1, 32'd1040, 32'h11223344, 1'b0, 1'b0, got);
    @(negedge clk);
    bus.rd_en = 1'b1; bus.address = 32'd1040;
    repeat (H + 2) @(negedge clk);
    chk("pre_rst_state_high", 32'(bus.state), 32'(HIGH));
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_state", 32'(bus.state), 32'(IDLE));
    chk("mid_rst_read_data", bus.read_data, 32'h0);
    chk("mid_rst_oe", 32'(sram_dq_oe), 32'd0);
    chk("mid_rst_we_n", 32'(sram_we_n), 32'd1);
    ref_rd = 32'h0;
    rst = 1'b0; bus.rd_en = 1'b0; bus.wr_en = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(bus.ready), 32'd1);
    run_access(1'b1, 1'b0, 32'd1040, 32'h0, 1'b0, 1'b0, got);
    chk("post_rst_read", got, 32'h11223344);

    // Randomized accesses with request changes injected mid-access.
    for (int n = 0; n < NRAND; n++) begin
      case ($urandom_range(0, 2))
        0:       begin op_rd = 1'b1; op_wr = 1'b0; end
        1:       begin op_rd = 1'b0; op_wr = 1'b1; end
        default: begin op_rd = 1'b1; op_wr = 1'b1; end
      endcase
      run_access(op_rd, op_wr, 32'd1024 + 4 * $urandom_range(0, 15), $urandom,
                 1'($urandom_range(0, 1)), 1'b1, got);
    end
    @(negedge clk);
    bus.rd_en = 1'b0; bus.wr_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("total_we_strobes", we_strobes, writes_done * 2 * (H - 1));
    chk("final_idle_ready", 32'(bus.ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
